// File: rtl/pixel_scan_writer.sv
// Pixel scan writer: walks a frame in raster order, issues one ray request
// per pixel, pairs in-order ray results with their coordinates through a tag
// FIFO and emits one registered framebuffer write per pixel.
//
// Handshake: a request transfers on a rising Clk edge where
// Req_Valid && Req_Ready. Once Req_Valid is high it stays high with Req_X/Req_Y
// unchanged until that transfer happens, even if Pause rises. Results have no
// backpressure: every Res_Valid cycle retires the oldest outstanding request.
module pixel_scan_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Frame_Clk,
    input  logic        Pause,
    output logic        Req_Valid,
    input  logic        Req_Ready,
    output logic [9:0]  Req_X,
    output logic [9:0]  Req_Y,
    input  logic        Res_Valid,
    input  logic [23:0] Res_Color,
    input  logic [1:0]  Res_Best_in,
    input  logic [63:0] Res_Best_Dist,
    output logic        WritePixel,
    output logic [9:0]  WriteX,
    output logic [9:0]  WriteY,
    output logic [23:0] WriteColor,
    output logic [1:0]  Best_in,
    output logic [63:0] Best_Dist,
    output logic        Frame_Busy,
    output logic        Frame_Done,
    output logic        Overrun,
    output logic        Orphan,
    output logic [1:0]  Dbg_State
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic        old_frame_clk_q;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic        req_hold_q, req_hold_d;
    logic        write_pixel_q, write_pixel_d;
    logic [9:0]  write_x_q, write_x_d, write_y_q, write_y_d;
    logic [23:0] write_color_q, write_color_d;
    logic [1:0]  best_in_q, best_in_d;
    logic [63:0] best_dist_q, best_dist_d;
    logic        frame_busy_q, frame_busy_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;
    logic        orphan_q, orphan_d;

    // Tag storage: {x, y} of each accepted request, oldest at rd_ptr_q.
    logic [19:0] fifo_q [FIFO_DEPTH];

    logic        rise;
    logic        req_valid;
    logic        push;
    logic        pop;
    logic [19:0] head;

    assign rise      = Frame_Clk && !old_frame_clk_q;
    // A held request ignores Pause; the FIFO cannot fill while it is held
    // because entries are only added on a transfer.
    assign req_valid = (state_q == ST_SCAN) &&
                       (req_hold_q || (!Pause && (count_q < CNT_FULL)));
    assign push      = req_valid && Req_Ready;
    assign pop       = Res_Valid && (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];

    assign Req_Valid  = req_valid;
    assign Req_X      = x_q;
    assign Req_Y      = y_q;
    assign WritePixel = write_pixel_q;
    assign WriteX     = write_x_q;
    assign WriteY     = write_y_q;
    assign WriteColor = write_color_q;
    assign Best_in    = best_in_q;
    assign Best_Dist  = best_dist_q;
    assign Frame_Busy = frame_busy_q;
    assign Frame_Done = frame_done_q;
    assign Overrun    = overrun_q;
    assign Orphan     = orphan_q;
    assign Dbg_State  = state_q;

    // Frame sequencing: start on a rise when idle, advance the raster on each
    // transfer, finish once every outstanding request has been written.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d      = ST_SCAN;
                    x_d          = '0;
                    y_d          = '0;
                    frame_busy_d = 1'b1;
                end
            end
            ST_SCAN: begin
                if (push) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // An empty FIFO here means the last pop already happened;
                // its write is on the outputs this cycle at the latest.
                if (count_q == '0) begin
                    state_d      = ST_IDLE;
                    frame_busy_d = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tag FIFO bookkeeping, result-to-write pairing and sticky error flags.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        req_hold_d    = req_valid && !Req_Ready;
        write_pixel_d = pop;
        write_x_d     = write_x_q;
        write_y_d     = write_y_q;
        write_color_d = write_color_q;
        best_in_d     = best_in_q;
        best_dist_d   = best_dist_q;
        overrun_d     = overrun_q;
        orphan_d      = orphan_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
            write_x_d     = head[19:10];
            write_y_d     = head[9:0];
            write_color_d = Res_Color;
            best_in_d     = Res_Best_in;
            best_dist_d   = Res_Best_Dist;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (rise && frame_busy_q) begin
            overrun_d = 1'b1;
        end
        if (Res_Valid && (count_q == '0)) begin
            orphan_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= ST_IDLE;
            old_frame_clk_q <= 1'b0;
            x_q             <= '0;
            y_q             <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            req_hold_q      <= 1'b0;
            write_pixel_q   <= 1'b0;
            write_x_q       <= '0;
            write_y_q       <= '0;
            write_color_q   <= '0;
            best_in_q       <= '0;
            best_dist_q     <= '0;
            frame_busy_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            overrun_q       <= 1'b0;
            orphan_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            old_frame_clk_q <= Frame_Clk;
            x_q             <= x_d;
            y_q             <= y_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            req_hold_q      <= req_hold_d;
            write_pixel_q   <= write_pixel_d;
            write_x_q       <= write_x_d;
            write_y_q       <= write_y_d;
            write_color_q   <= write_color_d;
            best_in_q       <= best_in_d;
            best_dist_q     <= best_dist_d;
            frame_busy_q    <= frame_busy_d;
            frame_done_q    <= frame_done_d;
            overrun_q       <= overrun_d;
            orphan_q        <= orphan_d;
        end
    end

    // Tag storage write port; contents are only meaningful below count_q.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {x_q, y_q};
        end
    end

endmodule

// File: tb/tb_pixel_scan_writer.sv
// Bench for pixel_scan_writer on a 6x3 frame with an 8-deep tag FIFO.
// A ray-core model answers accepted requests in order after a chosen latency;
// each scenario task compares the DUT against raster-order expectations.
module tb_pixel_scan_writer;

    localparam int H     = 6;
    localparam int V     = 3;
    localparam int N     = H * V;
    localparam int DEPTH = 8;
    localparam logic [63:0] MISS = 64'hEFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [23:0] c;
        logic [1:0]  b;
        logic [63:0] d;
    } res_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] c;
        logic [1:0]  b;
        logic [63:0] d;
    } wr_t;

    logic        Clk, Reset_n, Frame_Clk, Pause;
    logic        Req_Valid, Req_Ready;
    logic [9:0]  Req_X, Req_Y;
    logic        Res_Valid;
    logic [23:0] Res_Color;
    logic [1:0]  Res_Best_in;
    logic [63:0] Res_Best_Dist;
    logic        WritePixel;
    logic [9:0]  WriteX, WriteY;
    logic [23:0] WriteColor;
    logic [1:0]  Best_in;
    logic [63:0] Best_Dist;
    logic        Frame_Busy, Frame_Done, Overrun, Orphan;
    logic [1:0]  Dbg_State;

    int checks   = 0;
    int failures = 0;

    // Ray-core model controls and logs.
    int   cyc         = 0;
    int   ready_mode  = 0;   // 0 never ready, 1 always ready, 2 random
    int   lat_min     = 3;
    int   lat_max     = 3;
    int   res_budget  = 1 << 30;
    bit   inject_orphan = 1'b0;
    int   done_cnt    = 0;
    int   done_cyc    = -1;
    int   last_wr_cyc = -1;
    int   stab_err    = 0;
    res_t pend_q[$];
    int   due_q[$];
    res_t sent_q[$];
    logic [19:0] req_q[$];
    wr_t  obs_q[$];

    pixel_scan_writer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Clk(Frame_Clk), .Pause(Pause),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_X(Req_X), .Req_Y(Req_Y),
        .Res_Valid(Res_Valid), .Res_Color(Res_Color), .Res_Best_in(Res_Best_in),
        .Res_Best_Dist(Res_Best_Dist), .WritePixel(WritePixel), .WriteX(WriteX),
        .WriteY(WriteY), .WriteColor(WriteColor), .Best_in(Best_in),
        .Best_Dist(Best_Dist), .Frame_Busy(Frame_Busy), .Frame_Done(Frame_Done),
        .Overrun(Overrun), .Orphan(Orphan), .Dbg_State(Dbg_State)
    );

    // Clock and reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Ray-core model: drives results at the falling edge, samples at +3.
    initial begin : core_model
        res_t r_out, r_new;
        wr_t  w;
        bit   prev_stall;
        logic [19:0] prev_xy;
        prev_stall = 1'b0;
        prev_xy    = '0;
        Res_Valid = 1'b0; Res_Color = '0; Res_Best_in = '0; Res_Best_Dist = '0;
        Req_Ready = 1'b0;
        forever begin
            @(negedge Clk);
            Res_Valid = 1'b0;
            if (inject_orphan) begin
                Res_Valid     = 1'b1;
                Res_Color     = 24'($urandom);
                inject_orphan = 1'b0;
            end else if (res_budget > 0 && pend_q.size() > 0 && due_q[0] <= cyc) begin
                r_out = pend_q.pop_front();
                void'(due_q.pop_front());
                Res_Valid     = 1'b1;
                Res_Color     = r_out.c;
                Res_Best_in   = r_out.b;
                Res_Best_Dist = r_out.d;
                sent_q.push_back(r_out);
                res_budget--;
            end
            case (ready_mode)
                1:       Req_Ready = 1'b1;
                2:       Req_Ready = 1'($urandom_range(0, 1));
                default: Req_Ready = 1'b0;
            endcase
            #3;
            if (!Reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!Req_Valid || {Req_X, Req_Y} != prev_xy)) stab_err++;
                if (Req_Valid && Req_Ready) begin
                    r_new.c = 24'($urandom);
                    r_new.b = 2'($urandom);
                    r_new.d = {$urandom, $urandom};
                    if (Req_X == 10'(H / 2) && Req_Y == 10'(V / 2)) r_new.d = MISS;
                    req_q.push_back({Req_X, Req_Y});
                    pend_q.push_back(r_new);
                    due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
                end
                prev_stall = Req_Valid && !Req_Ready;
                prev_xy    = {Req_X, Req_Y};
                if (WritePixel) begin
                    w = {WriteX, WriteY, WriteColor, Best_in, Best_Dist};
                    obs_q.push_back(w);
                    last_wr_cyc = cyc;
                end
                if (Frame_Done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
            cyc++;
        end
    end

    // Expected k-th write of a frame: raster coordinate k with the k-th result.
    function automatic wr_t exp_at(int k);
        wr_t e;
        e.x = 10'(k % H);
        e.y = 10'(k / H);
        e.c = sent_q[k].c;
        e.b = sent_q[k].b;
        e.d = sent_q[k].d;
        return e;
    endfunction

    // Driver tasks: return 1 time unit after the falling edge.
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        obs_q.delete();
        req_q.delete();
        sent_q.delete();
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        steps(2);
        Reset_n = 1'b1;
        step();
    endtask

    task automatic start_frame();
        step();
        Frame_Clk = 1'b1;
        step();
        Frame_Clk = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s: Frame_Done not seen within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Frame_Clk = 1'b0; Pause = 1'b0;
        steps(3);
        checks++;
        if ({Req_Valid, Req_X, Req_Y, WritePixel, WriteX, WriteY, WriteColor, Best_in,
             Best_Dist, Frame_Busy, Frame_Done, Overrun, Orphan, Dbg_State} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero in reset (Req_Valid=%b Busy=%b Dist=%h)",
                     Req_Valid, Frame_Busy, Best_Dist);
        end
        Reset_n = 1'b1;
        steps(2);
        checks++;
        if (Req_Valid !== 1'b0 || Dbg_State !== 2'd0 || Frame_Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: Req_Valid=%b state=%0d busy=%b required 0/0/0",
                     Req_Valid, Dbg_State, Frame_Busy);
        end
    endtask

    task automatic test_frame();
        int d0;
        ready_mode = 1; lat_min = 3; lat_max = 3; Pause = 1'b0;
        clear_logs();
        d0 = done_cnt;
        start_frame();
        checks++;
        if (Frame_Busy !== 1'b1) begin
            failures++;
            $display("FAIL frame_busy_start: Frame_Busy=%b required 1", Frame_Busy);
        end
        wait_done("frame_done", 300);
        steps(5);
        checks++;
        if (req_q.size() != N) begin
            failures++;
            $display("FAIL frame_req_count: %0d requests required %0d", req_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (req_q[k] !== {10'(k % H), 10'(k / H)}) begin
                    failures++;
                    $display("FAIL frame_req_order[%0d]: got %h required %h", k, req_q[k],
                             {10'(k % H), 10'(k / H)});
                end
            end
        end
        checks++;
        if (obs_q.size() != N) begin
            failures++;
            $display("FAIL frame_write_count: %0d writes required %0d", obs_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (obs_q[k] !== exp_at(k)) begin
                    failures++;
                    $display("FAIL frame_write[%0d]: got %h required %h", k, obs_q[k], exp_at(k));
                end
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc != last_wr_cyc + 1) begin
            failures++;
            $display("FAIL frame_done_timing: pulses=%0d done_cyc=%0d required 1 pulse at %0d",
                     done_cnt - d0, done_cyc, last_wr_cyc + 1);
        end
        checks++;
        if (Frame_Busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_busy_end: Frame_Busy=%b required 0", Frame_Busy);
        end
    endtask

    task automatic test_stall();
        ready_mode = 0;
        clear_logs();
        start_frame();
        steps(20);
        checks++;
        if (Req_Valid !== 1'b1 || Req_X !== 10'd0 || Req_Y !== 10'd0) begin
            failures++;
            $display("FAIL stall_hold: valid=%b x=%0d y=%0d required 1,0,0", Req_Valid, Req_X, Req_Y);
        end
        checks++;
        if (req_q.size() != 0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL stall_activity: requests=%0d writes=%0d required 0,0",
                     req_q.size(), obs_q.size());
        end
        ready_mode = 1;
        wait_done("stall_done", 300);
        step();
        checks++;
        if (obs_q.size() != N) begin
            failures++;
            $display("FAIL stall_write_count: %0d writes required %0d", obs_q.size(), N);
        end
    endtask

    task automatic test_fifo_full();
        ready_mode = 1; lat_min = 1; lat_max = 1; res_budget = 0;
        clear_logs();
        start_frame();
        steps(20);
        checks++;
        if (req_q.size() != DEPTH || Req_Valid !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full: accepts=%0d valid=%b required %0d,0",
                     req_q.size(), Req_Valid, DEPTH);
        end
        res_budget = 1;
        step();
        checks++;
        if (Req_Valid !== 1'b0) begin
            failures++;
            $display("FAIL fifo_pop_same_cycle: valid=%b required 0", Req_Valid);
        end
        step();
        checks++;
        if (Req_Valid !== 1'b1) begin
            failures++;
            $display("FAIL fifo_reopen: valid=%b required 1", Req_Valid);
        end
        res_budget = 1 << 30;
        wait_done("fifo_done", 300);
        step();
        checks++;
        if (obs_q.size() != N) begin
            failures++;
            $display("FAIL fifo_write_count: %0d writes required %0d", obs_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (obs_q[k] !== exp_at(k)) begin
                    failures++;
                    $display("FAIL fifo_write[%0d]: got %h required %h", k, obs_q[k], exp_at(k));
                end
            end
        end
    endtask

    task automatic test_random_centre();
        int n;
        int ci;
        ci = (V / 2) * H + (H / 2);
        for (int it = 0; it < 3; it++) begin
            ready_mode = 2; lat_min = 1; lat_max = 6; stab_err = 0;
            clear_logs();
            start_frame();
            n = 0;
            while (obs_q.size() < N && n < 1000) begin
                step();
                Pause = 1'($urandom_range(0, 1));
                n++;
            end
            Pause = 1'b0;
            wait_done("random_done", 50);
            checks++;
            if (stab_err != 0) begin
                failures++;
                $display("FAIL random_req_stable: %0d stalled requests changed, required 0", stab_err);
            end
            checks++;
            if (obs_q.size() != N) begin
                failures++;
                $display("FAIL random_write_count: %0d writes required %0d", obs_q.size(), N);
            end else begin
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (obs_q[k] !== exp_at(k)) begin
                        failures++;
                        $display("FAIL random_write[%0d]: got %h required %h", k, obs_q[k], exp_at(k));
                    end
                end
                checks++;
                if (obs_q[ci].x !== 10'(H / 2) || obs_q[ci].y !== 10'(V / 2) || obs_q[ci].d !== MISS) begin
                    failures++;
                    $display("FAIL centre_miss: got (%0d,%0d) dist %h required (%0d,%0d) dist %h",
                             obs_q[ci].x, obs_q[ci].y, obs_q[ci].d, H / 2, V / 2, MISS);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int acc;
        int d0;
        ready_mode = 1; lat_min = 2; lat_max = 2;
        clear_logs();
        d0 = done_cnt;
        start_frame();
        steps(4);
        Frame_Clk = 1'b1;
        step();
        Frame_Clk = 1'b0;
        acc = req_q.size();
        checks++;
        if (Overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag: Overrun=%b required 1", Overrun);
        end
        checks++;
        if (Req_X !== 10'(acc % H) || Req_Y !== 10'(acc / H)) begin
            failures++;
            $display("FAIL overrun_counters: at (%0d,%0d) required (%0d,%0d)",
                     Req_X, Req_Y, acc % H, acc / H);
        end
        wait_done("overrun_done", 300);
        steps(3);
        checks++;
        if (obs_q.size() != N || done_cnt - d0 != 1 || Overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_frame: writes=%0d pulses=%0d Overrun=%b required %0d,1,1",
                     obs_q.size(), done_cnt - d0, Overrun, N);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        ready_mode = 1; lat_min = 3; lat_max = 3;
        clear_logs();
        start_frame();
        n = 0;
        while (obs_q.size() < N && n < 300) begin
            step();
            n++;
        end
        // Cycle after the final write: Frame_Done is up, rise now.
        Frame_Clk = 1'b1;
        checks++;
        if (Frame_Done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_pulse: Frame_Done=%b required 1", Frame_Done);
        end
        step();
        Frame_Clk = 1'b0;
        clear_logs();
        checks++;
        if (Frame_Busy !== 1'b1 || Overrun !== 1'b0 || Dbg_State !== 2'd1) begin
            failures++;
            $display("FAIL b2b_restart: busy=%b overrun=%b state=%0d required 1,0,1",
                     Frame_Busy, Overrun, Dbg_State);
        end
        wait_done("b2b_done", 300);
        step();
        checks++;
        if (obs_q.size() != N) begin
            failures++;
            $display("FAIL b2b_write_count: %0d writes required %0d", obs_q.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (obs_q[k] !== exp_at(k)) begin
                    failures++;
                    $display("FAIL b2b_write[%0d]: got %h required %h", k, obs_q[k], exp_at(k));
                end
            end
        end
    endtask

    task automatic test_orphan_reset();
        int w0;
        do_reset();
        clear_logs();
        inject_orphan = 1'b1;
        steps(3);
        checks++;
        if (Orphan !== 1'b1 || obs_q.size() != 0 || WritePixel !== 1'b0) begin
            failures++;
            $display("FAIL orphan_idle: Orphan=%b writes=%0d required 1,0", Orphan, obs_q.size());
        end
        do_reset();
        ready_mode = 1; lat_min = 5; lat_max = 5;
        clear_logs();
        start_frame();
        steps(6);
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Req_Valid, Req_X, Req_Y, WritePixel, WriteX, WriteY, WriteColor, Best_in,
             Best_Dist, Frame_Busy, Frame_Done, Overrun, Orphan, Dbg_State} !== '0) begin
            failures++;
            $display("FAIL async_reset: outputs nonzero (valid=%b busy=%b x=%0d) required all 0",
                     Req_Valid, Frame_Busy, Req_X);
        end
        w0 = obs_q.size();
        step();
        Reset_n = 1'b1;
        steps(8);
        checks++;
        if (Orphan !== 1'b1 || obs_q.size() != w0) begin
            failures++;
            $display("FAIL reset_inflight: Orphan=%b writes_after_reset=%0d required 1,0",
                     Orphan, obs_q.size() - w0);
        end
        pend_q.delete();
        due_q.delete();
        do_reset();
    endtask

    initial begin
        Reset_n = 1'b0; Frame_Clk = 1'b0; Pause = 1'b0;
        test_reset();
        test_frame();
        test_stall();
        test_fifo_full();
        test_random_centre();
        test_overrun();
        test_back_to_back();
        test_orphan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
